// File: rtl/dm_port_arbiter_if.sv
// Single requester port of the data-RAM arbiter: request fields in, completion out.
interface dm_port_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (output req, we, addr, size, wdata, input ack, err, rdata);
    modport slave  (input req, we, addr, size, wdata, output ack, err, rdata);
endinterface

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing one synchronous data RAM between the CPU load/store
// port (p0) and the debug/DMA port (p1); handles alignment, byte enables and lane steering.
module dm_port_arbiter #(
    parameter int unsigned AW = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dm_port_arbiter_if.slave       p0,
    dm_port_arbiter_if.slave       p1,
    output logic                   ram_en,
    output logic [3:0]             ram_we,
    output logic [AW-1:0]          ram_addr,
    output logic [31:0]            ram_wdata,
    input  logic [31:0]            ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR_RESP} state_t;

    state_t      state;
    logic        last;
    logic        win;
    logic [1:0]  lat_size;
    logic [1:0]  lat_lo;
    logic [1:0]  ack_q;
    logic [1:0]  err_q;

    logic        sel;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  sel_size;
    logic        sel_err;
    logic [3:0]  sel_be;
    logic [31:0] sel_steer;
    logic [31:0] rd_ext;

    // Winner selection and decode of the candidate request (only consumed in IDLE).
    always_comb begin
        sel       = (p0.req && p1.req) ? ~last : p1.req;
        sel_we    = sel ? p1.we    : p0.we;
        sel_addr  = sel ? p1.addr  : p0.addr;
        sel_size  = sel ? p1.size  : p0.size;
        sel_wdata = sel ? p1.wdata : p0.wdata;
        sel_be    = 4'b0000;
        sel_steer = sel_wdata;
        sel_err   = (sel_addr >> (AW + 2)) != 32'd0;
        case (sel_size)
            2'd0: begin
                sel_be = 4'b1111;
                if (sel_addr[1:0] != 2'b00) sel_err = 1'b1;
            end
            2'd1: begin
                sel_be    = sel_addr[1] ? 4'b1100 : 4'b0011;
                sel_steer = {2{sel_wdata[15:0]}};
                if (sel_addr[0]) sel_err = 1'b1;
            end
            2'd2: begin
                sel_be    = 4'(4'b0001 << sel_addr[1:0]);
                sel_steer = {4{sel_wdata[7:0]}};
            end
            default: sel_err = 1'b1;
        endcase
    end

    // Lane extraction of RAM read data, valid while in RESP.
    always_comb begin
        rd_ext = 32'h0;
        case (lat_size)
            2'd0:    rd_ext = ram_rdata;
            2'd1:    rd_ext = {16'h0, lat_lo[1] ? ram_rdata[31:16] : ram_rdata[15:0]};
            2'd2:    rd_ext = {24'h0, ram_rdata[{lat_lo, 3'b000} +: 8]};
            default: rd_ext = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            win       <= 1'b0;
            lat_size  <= 2'd0;
            lat_lo    <= 2'd0;
            ack_q     <= 2'b00;
            err_q     <= 2'b00;
            ram_en    <= 1'b0;
            ram_we    <= 4'b0000;
            ram_addr  <= '0;
            ram_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (p0.req || p1.req) begin
                        win      <= sel;
                        last     <= sel;
                        lat_size <= sel_size;
                        lat_lo   <= sel_addr[1:0];
                        if (sel_err) begin
                            state <= ERR_RESP;
                            ack_q <= {sel, ~sel};
                            err_q <= {sel, ~sel};
                        end else begin
                            state     <= ACCESS;
                            ram_en    <= 1'b1;
                            ram_we    <= sel_we ? sel_be : 4'b0000;
                            ram_addr  <= sel_addr[AW+1:2];
                            ram_wdata <= sel_steer;
                        end
                    end
                end
                ACCESS: begin
                    ram_en <= 1'b0;
                    ram_we <= 4'b0000;
                    ack_q  <= {win, ~win};
                    state  <= RESP;
                end
                RESP, ERR_RESP: begin
                    ack_q <= 2'b00;
                    err_q <= 2'b00;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign p0.ack   = ack_q[0];
    assign p1.ack   = ack_q[1];
    assign p0.err   = err_q[0];
    assign p1.err   = err_q[1];
    assign p0.rdata = (state == RESP && !win) ? rd_ext : 32'h0;
    assign p1.rdata = (state == RESP &&  win) ? rd_ext : 32'h0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed spec scenarios plus random single-port traffic
// checked against a byte-addressed memory model.
module tb_dm_port_arbiter;
    localparam int unsigned AW = 12;
    localparam int unsigned MB = 256;

    logic          clk;
    logic          rst_n;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic          bd_en;
    logic [AW-1:0] bd_addr;
    logic [31:0]   bd_data;
    logic [31:0]   ram [0:(1<<AW)-1];
    logic [7:0]    ref_mem [0:MB-1];

    int            checks;
    int            errors;
    logic [31:0]   last_rd;

    dm_port_arbiter_if p0_if();
    dm_port_arbiter_if p1_if();

    dm_port_arbiter #(.AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0        (p0_if),
        .p1        (p1_if),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with a backdoor write port used for preloading.
    always @(posedge clk) begin
        if (bd_en) begin
            ram[bd_addr] <= bd_data;
        end else if (ram_en) begin
            ram_rdata <= ram[ram_addr];
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
    endfunction

    function automatic bit is_err(input logic [31:0] addr, input logic [1:0] size);
        int n;
        n = size_bytes(size);
        return (size == 2'd3) || ((addr % 32'(n)) != 32'd0) || (addr >= (32'd4 << AW));
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = 32'h0;
        for (int j = 0; j < n; j++)
            if (int'(a) + j < MB) r[8*j +: 8] = ref_mem[int'(a) + j];
        return r;
    endfunction

    function automatic logic [31:0] get_ack(input int p);
        return (p == 0) ? 32'(p0_if.ack) : 32'(p1_if.ack);
    endfunction

    function automatic logic [31:0] get_err(input int p);
        return (p == 0) ? 32'(p0_if.err) : 32'(p1_if.err);
    endfunction

    function automatic logic [31:0] get_rdata(input int p);
        return (p == 0) ? p0_if.rdata : p1_if.rdata;
    endfunction

    task automatic set_port(input int p, input logic req, input logic we, input logic [31:0] addr,
                            input logic [1:0] size, input logic [31:0] wdata);
        if (p == 0) begin
            p0_if.req = req; p0_if.we = we; p0_if.addr = addr; p0_if.size = size; p0_if.wdata = wdata;
        end else begin
            p1_if.req = req; p1_if.we = we; p1_if.addr = addr; p1_if.size = size; p1_if.wdata = wdata;
        end
    endtask

    task automatic bd_write(input int w, input logic [31:0] v);
        bd_en   = 1'b1;
        bd_addr = AW'(w);
        bd_data = v;
        @(negedge clk);
        bd_en = 1'b0;
        for (int j = 0; j < 4; j++)
            if (4*w + j < MB) ref_mem[4*w + j] = v[8*j +: 8];
    endtask

    // One request on port p starting at a falling edge, with the port otherwise idle.
    task automatic txn(input int p, input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wdata, input bit chg);
        int          n;
        bit          e;
        logic [3:0]  be;
        logic [31:0] wrep;
        logic [31:0] exp_rd;
        n      = size_bytes(size);
        e      = is_err(addr, size);
        be     = 4'(((32'd1 << n) - 32'd1) << addr[1:0]);
        exp_rd = 32'h0;
        for (int i = 0; i < 4; i++) wrep[8*i +: 8] = wdata[8*(i % n) +: 8];
        if (!we && !e) exp_rd = ref_read(addr, n);
        set_port(p, 1'b1, we, addr, size, wdata);
        @(negedge clk);
        if (e) begin
            chk("err_ack", get_ack(p), 32'd1);
            chk("err_flag", get_err(p), 32'd1);
            chk("err_rdata", get_rdata(p), 32'h0);
            chk("err_no_ram_en", 32'(ram_en), 32'd0);
            chk("err_other_ack", get_ack(1 - p), 32'd0);
            set_port(p, 1'b0, we, addr, size, wdata);
        end else begin
            chk("acc_ram_en", 32'(ram_en), 32'd1);
            chk("acc_ram_we", 32'(ram_we), we ? 32'(be) : 32'd0);
            chk("acc_ram_addr", 32'(ram_addr), 32'(addr[AW+1:2]));
            chk("acc_ram_wdata", ram_wdata, wrep);
            chk("acc_no_ack", get_ack(p), 32'd0);
            if (chg) begin
                set_port(p, 1'b0, ~we, addr ^ 32'h1c, size, ~wdata);
                #1;
                chk("chg_ram_addr", 32'(ram_addr), 32'(addr[AW+1:2]));
                chk("chg_ram_wdata", ram_wdata, wrep);
                chk("chg_ram_we", 32'(ram_we), we ? 32'(be) : 32'd0);
            end
            @(negedge clk);
            chk("resp_ack", get_ack(p), 32'd1);
            chk("resp_err", get_err(p), 32'd0);
            chk("resp_other_ack", get_ack(1 - p), 32'd0);
            chk("resp_ram_en", 32'(ram_en), 32'd0);
            if (!we) chk("resp_rdata", get_rdata(p), exp_rd);
            last_rd = get_rdata(p);
            set_port(p, 1'b0, we, addr, size, wdata);
            if (we)
                for (int j = 0; j < n; j++)
                    if (int'(addr) + j < MB) ref_mem[int'(addr) + j] = wdata[8*j +: 8];
        end
        @(negedge clk);
        chk("post_ack", get_ack(p), 32'd0);
        chk("post_ram_en", 32'(ram_en), 32'd0);
    endtask

    initial begin
        logic [31:0] rd0;
        logic [31:0] rd1;
        checks = 0;
        errors = 0;
        last_rd = 32'h0;
        bd_en = 1'b0;
        bd_addr = '0;
        bd_data = 32'h0;
        set_port(0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack0", 32'(p0_if.ack), 32'd0);
        chk("rst_ack1", 32'(p1_if.ack), 32'd0);
        chk("rst_err0", 32'(p0_if.err), 32'd0);
        chk("rst_rdata0", p0_if.rdata, 32'h0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        rst_n = 1'b1;

        for (int w = 0; w < int'(MB / 4); w++) bd_write(w, $urandom);
        bd_write(0, 32'hBEEF1234);
        bd_write(1, 32'h11002233);

        txn(0, 1'b1, 32'h6, 2'd2, 32'h000000AB, 1'b0);
        txn(0, 1'b0, 32'h6, 2'd2, 32'h0, 1'b0);
        chk("byte_load_value", last_rd, 32'h000000AB);
        txn(0, 1'b0, 32'h2, 2'd1, 32'h0, 1'b0);
        chk("half_load_value", last_rd, 32'h0000BEEF);
        txn(0, 1'b1, 32'h8, 2'd0, 32'hCAFEF00D, 1'b0);

        txn(0, 1'b0, 32'h5, 2'd0, 32'h0, 1'b0);
        txn(1, 1'b1, 32'h3, 2'd1, 32'h1234, 1'b0);
        txn(0, 1'b0, 32'h0, 2'd3, 32'h0, 1'b0);
        txn(1, 1'b0, 32'h00004000, 2'd0, 32'h0, 1'b0);

        txn(1, 1'b1, 32'h10, 2'd0, 32'h12345678, 1'b1);
        txn(0, 1'b0, 32'h10, 2'd0, 32'h0, 1'b0);
        chk("chg_store_value", last_rd, 32'h12345678);
        txn(0, 1'b0, 32'hC, 2'd0, 32'h0, 1'b0);

        // Reset in the middle of a store's RAM access.
        set_port(0, 1'b1, 1'b1, 32'h100, 2'd0, 32'hDEADBEEF);
        @(negedge clk);
        chk("mid_rst_pre_en", 32'(ram_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ram_en", 32'(ram_en), 32'd0);
        chk("mid_rst_ram_we", 32'(ram_we), 32'd0);
        set_port(0, 1'b1, 1'b0, 32'h0, 2'd0, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h4, 2'd0, 32'h0);
        rd0 = ref_read(32'h0, 4);
        rd1 = ref_read(32'h4, 4);
        @(negedge clk);
        chk("mid_rst_no_ack", 32'(p0_if.ack), 32'd0);
        rst_n = 1'b1;

        // Continuous contention: one 3-cycle transaction per slot, ports alternate from 0.
        for (int i = 1; i <= 11; i++) begin
            bit slot_ack;
            int k;
            @(negedge clk);
            slot_ack = (i % 3 == 2);
            k = i / 3;
            chk("cont_ack0", 32'(p0_if.ack), 32'(slot_ack && (k % 2 == 0)));
            chk("cont_ack1", 32'(p1_if.ack), 32'(slot_ack && (k % 2 == 1)));
            if (i % 3 == 1) begin
                chk("cont_ram_en", 32'(ram_en), 32'd1);
                chk("cont_grant_addr", 32'(ram_addr), 32'(k % 2));
            end
            if (slot_ack && (k % 2 == 0)) chk("cont_rdata0", p0_if.rdata, rd0);
            if (slot_ack && (k % 2 == 1)) chk("cont_rdata1", p1_if.rdata, rd1);
        end
        set_port(0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
        @(negedge clk);
        chk("cont_idle_en", 32'(ram_en), 32'd0);

        for (int it = 0; it < 80; it++) begin
            int          p;
            int          r;
            logic        we;
            logic [1:0]  size;
            logic [31:0] addr;
            p    = int'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            r    = int'($urandom_range(0, 9));
            if (r == 0)
                addr = (32'($urandom) & 32'hFFFF_FFFC) | 32'h0000_4000;
            else if (r <= 2)
                addr = 32'($urandom_range(0, MB - 1));
            else
                addr = 32'($urandom_range(0, MB - 1)) & ~(32'(size_bytes(size)) - 32'd1);
            txn(p, we, addr, size, 32'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
